// File: rtl/ucaspian_step_ctrl_if.sv
// Host/pipeline signal bundle for the uCaspian time-step sequencer.
// The slave modport is the sequencer; the master modport is host plus pipeline.
interface ucaspian_step_ctrl_if #(
  parameter int NUM_DONE = 3,
  parameter int TIME_W   = 16
);
  logic [1:0]          cmd_op;
  logic [TIME_W-1:0]   cmd_steps;
  logic                cmd_vld;
  logic                cmd_rdy;
  logic                halt;
  logic                clear_act;
  logic                clear_config;
  logic                clear_done;
  logic                next_step;
  logic [NUM_DONE-1:0] step_done;
  logic [TIME_W-1:0]   time_now;
  logic                done_vld;
  logic                done_rdy;
  logic [1:0]          done_op;
  logic [TIME_W-1:0]   done_steps;
  logic                busy;

  modport slave (
    input  cmd_op, cmd_steps, cmd_vld, halt, clear_done, step_done, done_rdy,
    output cmd_rdy, clear_act, clear_config, next_step, time_now,
           done_vld, done_op, done_steps, busy
  );

  modport master (
    output cmd_op, cmd_steps, cmd_vld, halt, clear_done, step_done, done_rdy,
    input  cmd_rdy, clear_act, clear_config, next_step, time_now,
           done_vld, done_op, done_steps, busy
  );
endinterface

// File: rtl/ucaspian_step_ctrl.sv
// Time-step sequencer for the uCaspian core: runs N steps, clears pipeline state,
// keeps the global time counter and reports each command's completion to the host.
module ucaspian_step_ctrl #(
  parameter int NUM_DONE     = 3,
  parameter int QUIET_CYCLES = 4,
  parameter int TIME_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  ucaspian_step_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam logic [1:0]        OP_RUN     = 2'd0;
  localparam logic [1:0]        OP_CLR_ACT = 2'd1;
  localparam logic [1:0]        OP_CLR_CFG = 2'd2;
  localparam logic [1:0]        OP_ZERO    = 2'd3;
  localparam logic [TIME_W-1:0] ZERO_T     = {TIME_W{1'b0}};
  localparam logic [TIME_W-1:0] ONE_T      = {{(TIME_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        QUIET_LAST = 4'(QUIET_CYCLES - 1);
  localparam logic [1:0]        DRAIN_SKIP = 2'd2;

  state_t             r_state, w_state;
  logic [1:0]         r_op, w_op;
  logic [TIME_W-1:0]  r_remaining, w_remaining;
  logic [TIME_W-1:0]  r_executed, w_executed;
  logic [TIME_W-1:0]  r_time, w_time;
  logic [1:0]         r_drain_cnt, w_drain_cnt;
  logic [3:0]         r_quiet, w_quiet;
  logic               r_clr_first, w_clr_first;

  logic               r_cmd_rdy;
  logic               r_clear_act;
  logic               r_clear_config;
  logic               r_next_step;
  logic               r_done_vld;
  logic               r_busy;

  // Next-state and datapath update; outputs are registered from the next state.
  always_comb begin
    w_state     = r_state;
    w_op        = r_op;
    w_remaining = r_remaining;
    w_executed  = r_executed;
    w_time      = r_time;
    w_drain_cnt = r_drain_cnt;
    w_quiet     = r_quiet;
    w_clr_first = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_vld && r_cmd_rdy) begin
          w_op        = bus.cmd_op;
          w_executed  = ZERO_T;
          w_remaining = bus.cmd_steps;
          case (bus.cmd_op)
            OP_RUN: begin
              if (bus.cmd_steps == ZERO_T) begin
                w_state = S_REPORT;
              end else begin
                w_state = S_STEP;
              end
            end
            OP_CLR_ACT, OP_CLR_CFG: begin
              w_state     = S_CLEAR;
              w_clr_first = 1'b1;
            end
            OP_ZERO: begin
              w_time  = ZERO_T;
              w_state = S_REPORT;
            end
            default: begin
              w_state = S_IDLE;
            end
          endcase
        end else begin
          w_state = S_IDLE;
        end
      end

      // A clear_done seen on the first CLEAR cycle belongs to an earlier sweep.
      S_CLEAR: begin
        if (!r_clr_first && bus.clear_done) begin
          w_time  = ZERO_T;
          w_state = S_REPORT;
        end else begin
          w_state = S_CLEAR;
        end
      end

      S_STEP: begin
        w_state     = S_DRAIN;
        w_drain_cnt = 2'd0;
        w_quiet     = 4'd0;
      end

      // step_done lags next_step by the pipeline's register stage, so skip two cycles.
      S_DRAIN: begin
        if (r_drain_cnt != DRAIN_SKIP) begin
          w_drain_cnt = r_drain_cnt + 2'd1;
        end else if (&bus.step_done) begin
          if (r_quiet == QUIET_LAST) begin
            w_quiet     = 4'd0;
            w_time      = r_time + ONE_T;
            w_executed  = r_executed + ONE_T;
            w_remaining = r_remaining - ONE_T;
            if ((w_remaining == ZERO_T) || bus.halt) begin
              w_state = S_REPORT;
            end else begin
              w_state = S_STEP;
            end
          end else begin
            w_quiet = r_quiet + 4'd1;
          end
        end else begin
          w_quiet = 4'd0;
        end
      end

      S_REPORT: begin
        if (bus.done_rdy) begin
          w_state = S_IDLE;
        end else begin
          w_state = S_REPORT;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= 2'd0;
      r_remaining    <= ZERO_T;
      r_executed     <= ZERO_T;
      r_time         <= ZERO_T;
      r_drain_cnt    <= 2'd0;
      r_quiet        <= 4'd0;
      r_clr_first    <= 1'b0;
      r_cmd_rdy      <= 1'b1;
      r_clear_act    <= 1'b0;
      r_clear_config <= 1'b0;
      r_next_step    <= 1'b0;
      r_done_vld     <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_op           <= w_op;
      r_remaining    <= w_remaining;
      r_executed     <= w_executed;
      r_time         <= w_time;
      r_drain_cnt    <= w_drain_cnt;
      r_quiet        <= w_quiet;
      r_clr_first    <= w_clr_first;
      r_cmd_rdy      <= (w_state == S_IDLE);
      r_clear_act    <= (w_state == S_CLEAR);
      r_clear_config <= (w_state == S_CLEAR) && (w_op == OP_CLR_CFG);
      r_next_step    <= (w_state == S_STEP);
      r_done_vld     <= (w_state == S_REPORT);
      r_busy         <= (w_state != S_IDLE);
    end
  end

  assign bus.cmd_rdy      = r_cmd_rdy;
  assign bus.clear_act    = r_clear_act;
  assign bus.clear_config = r_clear_config;
  assign bus.next_step    = r_next_step;
  assign bus.time_now     = r_time;
  assign bus.done_vld     = r_done_vld;
  assign bus.done_op      = r_op;
  assign bus.done_steps   = r_executed;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Scoreboard bench for ucaspian_step_ctrl: a small pipeline model answers next_step,
// expected reports are queued at command issue and compared at the done handshake.
module tb_ucaspian_step_ctrl;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] steps;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ucaspian_step_ctrl_if #(.NUM_DONE(3), .TIME_W(16)) ifc ();
  ucaspian_step_ctrl_if #(.NUM_DONE(3), .TIME_W(4))  ifw ();

  ucaspian_step_ctrl #(.NUM_DONE(3), .QUIET_CYCLES(4), .TIME_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // Narrow instance so that the time wrap is reachable in a short run.
  ucaspian_step_ctrl #(.NUM_DONE(3), .QUIET_CYCLES(1), .TIME_W(4)) u_dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (ifw.slave)
  );

  assign ifw.step_done = 3'b111;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          pulse_cnt = 0;
  int          cyc = 0;
  int          last_pulse = -1;
  int          min_gap = 1000000;
  int          dly = 0;
  bit          glitch_en = 1'b0;
  logic [15:0] tm = 16'd0;

  // Pipeline model: done flags drop on next_step and return 5 cycles later.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (ifc.next_step === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      dly = 5;
    end else if (dly != 0) begin
      dly = dly - 1;
    end
    ifc.step_done = (dly == 0) ? 3'b111 : 3'b000;
    if (glitch_en && (cyc % 3 == 0)) ifc.step_done[1] = 1'b0;
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] steps,
                       input logic [15:0] exp_steps, input bit expect_report);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    ifc.cmd_op = op; ifc.cmd_steps = steps; ifc.cmd_vld = 1'b1;
    while (ifc.cmd_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ifc.cmd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL cmd_accept: cmd_rdy=%b want 1", ifc.cmd_rdy);
    end
    @(posedge clk);
    #1;
    ifc.cmd_vld = 1'b0; ifc.cmd_op = 2'd0; ifc.cmd_steps = 16'd0;
    if (expect_report) begin
      e.op = op; e.steps = exp_steps;
      sb.push_back(e);
    end
  endtask

  task automatic wait_report(input int limit, input logic [15:0] exp_time);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (ifc.done_vld !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ifc.done_vld !== 1'b1) begin
      bad++;
      $display("FAIL report_timeout: done_vld=%b want 1 within %0d cycles", ifc.done_vld, limit);
      if (sb.size() != 0) e = sb.pop_front();
      return;
    end
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL report_unexpected: op=%0d steps=%0d with empty scoreboard", ifc.done_op, ifc.done_steps);
    end else begin
      e = sb.pop_front();
      if (ifc.done_op !== e.op || ifc.done_steps !== e.steps || ifc.time_now !== exp_time) begin
        bad++;
        $display("FAIL report_data: op=%0d steps=%0d time=%0h want op=%0d steps=%0d time=%0h",
                 ifc.done_op, ifc.done_steps, ifc.time_now, e.op, e.steps, exp_time);
      end
    end
    ifc.done_rdy = 1'b1;
    @(negedge clk);
    ifc.done_rdy = 1'b0;
    total++;
    if (ifc.done_vld !== 1'b0 || ifc.cmd_rdy !== 1'b1 || ifc.busy !== 1'b0) begin
      bad++;
      $display("FAIL report_release: done_vld=%b cmd_rdy=%b busy=%b want 0 1 0",
               ifc.done_vld, ifc.cmd_rdy, ifc.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ifc.cmd_rdy !== 1'b1 || ifc.clear_act !== 1'b0 || ifc.clear_config !== 1'b0 ||
        ifc.next_step !== 1'b0 || ifc.done_vld !== 1'b0 || ifc.busy !== 1'b0 ||
        ifc.time_now !== 16'd0 || ifc.done_op !== 2'd0 || ifc.done_steps !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b ca=%b cc=%b ns=%b dv=%b busy=%b t=%0h want 1 0 0 0 0 0 0",
               ifc.cmd_rdy, ifc.clear_act, ifc.clear_config, ifc.next_step,
               ifc.done_vld, ifc.busy, ifc.time_now);
    end
    reset = 1'b0;
  endtask

  task automatic test_run3();
    int base;
    base = pulse_cnt;
    issue(2'd0, 16'd3, 16'd3, 1'b1);
    tm = tm + 16'd3;
    wait_report(300, tm);
    total++;
    if (pulse_cnt - base != 3) begin
      bad++;
      $display("FAIL run3_pulses: got %0d want 3", pulse_cnt - base);
    end
  endtask

  task automatic test_run0();
    int base;
    base = pulse_cnt;
    issue(2'd0, 16'd0, 16'd0, 1'b1);
    wait_report(20, tm);
    total++;
    if (pulse_cnt != base) begin
      bad++;
      $display("FAIL run0_pulses: got %0d want 0", pulse_cnt - base);
    end
  endtask

  task automatic test_clear(input logic [1:0] op, input bit stale, input int hold, input int exp_hi);
    int hi, cfg_hi, n;
    hi = 0; cfg_hi = 0; n = 0;
    ifc.clear_done = stale;
    issue(op, 16'h1234, 16'd0, 1'b1);
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (ifc.clear_act === 1'b1) hi++;
      if (ifc.clear_config === 1'b1) cfg_hi++;
      if (hi == hold) ifc.clear_done = 1'b1;
      if (ifc.clear_act !== 1'b1) break;
    end
    ifc.clear_done = 1'b0;
    total++;
    if (hi != exp_hi || cfg_hi != ((op == 2'd2) ? exp_hi : 0)) begin
      bad++;
      $display("FAIL clear_len: clear_act=%0d clear_config=%0d cycles want %0d %0d",
               hi, cfg_hi, exp_hi, (op == 2'd2) ? exp_hi : 0);
    end
    tm = 16'd0;
    wait_report(20, tm);
  endtask

  task automatic test_halt();
    int base, n;
    base = pulse_cnt; n = 0;
    issue(2'd0, 16'd10, 16'd2, 1'b1);
    while (pulse_cnt - base < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ifc.halt = 1'b1;
    tm = tm + 16'd2;
    wait_report(200, tm);
    ifc.halt = 1'b0;
    total++;
    if (pulse_cnt - base != 2) begin
      bad++;
      $display("FAIL halt_pulses: got %0d want 2", pulse_cnt - base);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = pulse_cnt;
    glitch_en = 1'b1;
    issue(2'd0, 16'd2, 16'd2, 1'b1);
    repeat (60) @(negedge clk);
    total++;
    if (pulse_cnt - base != 1 || ifc.done_vld !== 1'b0) begin
      bad++;
      $display("FAIL glitch_hold: pulses=%0d done_vld=%b want 1 0", pulse_cnt - base, ifc.done_vld);
    end
    glitch_en = 1'b0;
    tm = tm + 16'd2;
    wait_report(200, tm);
    total++;
    if (pulse_cnt - base != 2) begin
      bad++;
      $display("FAIL glitch_pulses: got %0d want 2", pulse_cnt - base);
    end
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    issue(2'd0, 16'd1, 16'd1, 1'b1);
    tm = tm + 16'd1;
    while (ifc.done_vld !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (ifc.done_vld !== 1'b1 || ifc.done_op !== 2'd0 || ifc.done_steps !== 16'd1 ||
          ifc.cmd_rdy !== 1'b0 || ifc.time_now !== tm) begin
        bad++;
        $display("FAIL stall_stable: vld=%b op=%0d steps=%0d rdy=%b t=%0h want 1 0 1 0 %0h",
                 ifc.done_vld, ifc.done_op, ifc.done_steps, ifc.cmd_rdy, ifc.time_now, tm);
      end
    end
    wait_report(5, tm);
  endtask

  task automatic test_reset_mid();
    int base, n;
    base = pulse_cnt; n = 0;
    issue(2'd0, 16'd5, 16'd0, 1'b0);
    while (pulse_cnt - base < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (ifc.cmd_rdy !== 1'b1 || ifc.next_step !== 1'b0 || ifc.done_vld !== 1'b0 ||
        ifc.busy !== 1'b0 || ifc.time_now !== 16'd0 || ifc.done_steps !== 16'd0 ||
        ifc.clear_act !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: rdy=%b ns=%b dv=%b busy=%b t=%0h want 1 0 0 0 0",
               ifc.cmd_rdy, ifc.next_step, ifc.done_vld, ifc.busy, ifc.time_now);
    end
    reset = 1'b0;
    tm = 16'd0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.done_vld === 1'b1) n++;
    end
    total++;
    if (n != 0 || pulse_cnt - base != 1) begin
      bad++;
      $display("FAIL reset_quiet: done_vld cycles=%0d pulses=%0d want 0 1", n, pulse_cnt - base);
    end
  endtask

  task automatic w_cmd(input logic [1:0] op, input logic [3:0] steps,
                       input logic [3:0] exp_steps, input logic [3:0] exp_time);
    int n;
    n = 0;
    @(negedge clk);
    ifw.cmd_op = op; ifw.cmd_steps = steps; ifw.cmd_vld = 1'b1;
    @(posedge clk);
    #1;
    ifw.cmd_vld = 1'b0;
    @(negedge clk);
    while (ifw.done_vld !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ifw.done_vld !== 1'b1 || ifw.done_op !== op || ifw.done_steps !== exp_steps ||
        ifw.time_now !== exp_time) begin
      bad++;
      $display("FAIL wrap_report: vld=%b op=%0d steps=%0d time=%0h want 1 %0d %0d %0h",
               ifw.done_vld, ifw.done_op, ifw.done_steps, ifw.time_now, op, exp_steps, exp_time);
    end
    ifw.done_rdy = 1'b1;
    @(negedge clk);
    ifw.done_rdy = 1'b0;
  endtask

  task automatic test_wrap();
    w_cmd(2'd3, 4'd0, 4'd0, 4'h0);
    w_cmd(2'd0, 4'hF, 4'hF, 4'hF);
    w_cmd(2'd0, 4'd1, 4'd1, 4'h0);
  endtask

  initial begin
    reset = 1'b1;
    ifc.cmd_op = 2'd0; ifc.cmd_steps = 16'd0; ifc.cmd_vld = 1'b0;
    ifc.halt = 1'b0; ifc.clear_done = 1'b0; ifc.done_rdy = 1'b0;
    ifw.cmd_op = 2'd0; ifw.cmd_steps = 4'd0; ifw.cmd_vld = 1'b0;
    ifw.halt = 1'b0; ifw.clear_done = 1'b0; ifw.done_rdy = 1'b0;

    test_reset();
    test_run3();
    test_clear(2'd1, 1'b1, 1000, 2);
    test_run0();
    test_halt();
    test_clear(2'd2, 1'b0, 258, 258);
    test_glitch();
    test_backpressure();
    test_wrap();
    test_reset_mid();

    total++;
    if (min_gap < 7) begin
      bad++;
      $display("FAIL step_spacing: min gap %0d cycles want >= 7", min_gap);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
